spi_pwm_peripheral: RTL and testbench
=====================================

# spi_pwm_peripheral

SPI-controlled 16-channel output and PWM peripheral for a TinyTapeout tile. A write-only SPI target (mode 0) loads five 8-bit configuration registers; these select, per output pin, constant-low, constant-high or a shared ~3 kHz PWM waveform with an 8-bit duty cycle. All 16 outputs drive `uo_out` and `uio_out`.

## Interface
Parameters:
- `PWM_DIV`, default 13: system clocks per PWM phase step. The PWM period is 256·`PWM_DIV` clocks, i.e. 3328 clocks ≈ 3.0 kHz at 10 MHz.

Ports:
- `clk`  in  1  system clock, 10 MHz nominal.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-high. The port keeps the codebase name, but reset is asserted when `rst_n`=1.
- `ena`  in  1  tile enable; ignored.
- `ui_in`  in  8  [0] SCLK, [1] COPI, [2] nCS; [7:3] unused.
- `uo_out`  out  8  outputs 7..0.
- `uio_in`  in  8  unused.
- `uio_out`  out  8  outputs 15..8.
- `uio_oe`  out  8  constant 8'hFF.

## Operation
- Registers, all reset to 8'h00:
  - 0x00 EN_OUT[7:0]
  - 0x01 EN_OUT[15:8]
  - 0x02 EN_PWM[7:0]
  - 0x03 EN_PWM[15:8]
  - 0x04 DUTY
- Output bit i = EN_OUT[i] ? (EN_PWM[i] ? pwm : 1) : 0.
- SPI inputs pass through synchronizers, then edge detection. A transaction begins on the synchronized nCS falling edge, which clears the bit counter and the shift register.
- COPI is shifted MSB-first on each synchronized SCLK rising edge while nCS is low. SCLK falling edges are ignored.
- Frame format is 16 bits: [15] R/W (1 = write), [14:8] address, [7:0] data.
- Commit happens on the synchronized nCS rising edge. The addressed register is written only when all of these hold:
  - exactly 16 bits were received;
  - bit 15 = 1;
  - address ≤ 0x04.
- All other frames are discarded with no state change: reads, short frames, long frames (more than 16 bits), and addresses above 0x04. Registers are write-only; there is no CIPO.
- PWM block:
  - A prescaler counts 0..`PWM_DIV`-1.
  - On wrap, the 8-bit phase counter increments (it wraps 255→0).
  - pwm = (DUTY == 8'hFF) ? 1 : (phase < DUTY). So DUTY 0x00 gives constant 0 and 0xFF gives constant 1.
  - Counters run freely and are never restarted by register writes.
- Reset mid-transaction aborts the frame, clears the bit counter, registers and counters. The SPI frame in progress is lost.

## Timing
- All outputs are 0 in reset; `uio_oe` = 8'hFF always.
- SCLK high and low phases must each be ≥ 4 `clk` cycles. nCS setup and hold around SCLK must be ≥ 4 `clk` cycles.
- Register update becomes visible on the outputs ≤ 5 `clk` after nCS rises on the pins.
- pwm and all outputs are registered: 1 cycle from the phase compare.
- A DUTY change takes effect at the next phase compare; there is no period-boundary latching.

## Configuration
- `SPI_SYNC2_EN` defined: two-flop synchronizers on SCLK, COPI and nCS, giving a worst-case commit latency of 5 clocks.
- Undefined: single-flop input registers only, giving a worst-case commit latency of 4 clocks. SPI timing rules are unchanged.

## Test plan
- Reset: hold `rst_n`=1 for 5 cycles → `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xFF.
- Static outputs: write 0x00←0xF0 and 0x01←0xCC → `uo_out`=0xF0, `uio_out`=0xCC within 5 clocks of nCS high.
- PWM at 50 %:
  - writes: 0x00←0x01, 0x02←0x01, 0x04←0x80;
  - required: `uo_out`[0] period 3328±1 clocks, high time 1664±13 clocks.
- Duty extremes: DUTY 0x00 → bit 0 constant 0 over 2 periods; DUTY 0xFF → constant 1 over 2 periods.
- Rejected frames, with registers unchanged:
  - read frame 0x0055;
  - address 0x05;
  - 15-bit frame;
  - 17-bit frame.
- Reset in mid-frame: assert reset after 8 bits, release, send a full write 0x00←0x0F → `uo_out`=0x0F.

Source files
------------

// File: rtl/spi_pwm_peripheral.sv
// spi_pwm_peripheral: write-only SPI (mode 0) target that loads five 8-bit
// configuration registers selecting, per output pin, constant-low,
// constant-high or a shared PWM waveform with an 8-bit duty cycle.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous reset, asserted HIGH (legacy port name kept)
//   ena      tile enable, ignored
//   ui_in    [0] SCLK, [1] COPI, [2] nCS; [7:3] unused
//   uo_out   outputs 7..0
//   uio_in   unused
//   uio_out  outputs 15..8
//   uio_oe   constant 8'hFF
//
// Build option: define SPI_SYNC2_EN for two-flop input synchronizers;
// default is a single input register stage.
module spi_pwm_peripheral #(
    parameter int unsigned PWM_DIV = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(17);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    // Idle pin state {ncs, copi, sclk}: nCS high so reset creates no false edge
    localparam logic [2:0] PIN_IDLE = 3'b100;

    logic rst;
    assign rst = rst_n;

    logic unused_in;
    assign unused_in = &{1'b0, ena, ui_in[7:3], uio_in};

    logic [2:0]       sync_q, sync_d;
    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]      shift_q, shift_d;
    logic [15:0]      en_out_q, en_out_d;
    logic [15:0]      en_pwm_q, en_pwm_d;
    logic [7:0]       duty_q, duty_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       phase_q, phase_d;
    logic [15:0]      out_q, out_d;

    logic sclk_rise, ncs_fall, ncs_rise, wr_ok, pwm_c;

`ifdef SPI_SYNC2_EN
    logic [2:0] meta_q, meta_d;

    // First synchronizer stage
    always_comb meta_d = ui_in[2:0];

    always_ff @(posedge clk) begin
        if (rst) meta_q <= PIN_IDLE;
        else     meta_q <= meta_d;
    end

    always_comb sync_d = meta_q;
`else
    always_comb sync_d = ui_in[2:0];
`endif

    // SPI edge detection, frame shifting, commit, PWM and output mux
    always_comb begin
        prev_d    = sync_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        en_out_d  = en_out_q;
        en_pwm_d  = en_pwm_q;
        duty_d    = duty_q;
        pre_d     = pre_q;
        phase_d   = phase_q;

        sclk_rise = sync_q[0] & ~prev_q[0];
        ncs_fall  = ~sync_q[2] & prev_q[2];
        ncs_rise  = sync_q[2] & ~prev_q[2];

        if (ncs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (sclk_rise && !sync_q[2]) begin
            shift_d = {shift_q[14:0], sync_q[1]};
            // Saturate past 16 so long frames stay distinguishable
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        wr_ok = ncs_rise && (bit_cnt_q == CNT_FULL) && shift_q[15]
                && (shift_q[14:8] <= 7'h04);
        if (wr_ok) begin
            case (shift_q[10:8])
                3'd0:    en_out_d[7:0]  = shift_q[7:0];
                3'd1:    en_out_d[15:8] = shift_q[7:0];
                3'd2:    en_pwm_d[7:0]  = shift_q[7:0];
                3'd3:    en_pwm_d[15:8] = shift_q[7:0];
                3'd4:    duty_d         = shift_q[7:0];
                default: ;
            endcase
        end

        // Free-running prescaler and phase counter
        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            phase_d = phase_q + 8'd1;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        pwm_c = (duty_q == 8'hFF) || (phase_q < duty_q);
        out_d = en_out_q & (~en_pwm_q | {16{pwm_c}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= PIN_IDLE;
            prev_q    <= PIN_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            en_out_q  <= '0;
            en_pwm_q  <= '0;
            duty_q    <= '0;
            pre_q     <= '0;
            phase_q   <= '0;
            out_q     <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            en_out_q  <= en_out_d;
            en_pwm_q  <= en_pwm_d;
            duty_q    <= duty_d;
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            out_q     <= out_d;
        end
    end

    assign uo_out  = out_q[7:0];
    assign uio_out = out_q[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_spi_pwm_peripheral.sv
// Self-checking bench for spi_pwm_peripheral: vector table of SPI frames with
// expected outputs, PWM timing measurement, reset-in-frame sequence, and
// random frames checked against a time-based reference model.
`timescale 1ns/1ps
module tb_spi_pwm_peripheral;
    localparam int unsigned PWM_DIV = 13;
    localparam int unsigned PERIOD  = 256 * PWM_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    assign ui_in  = {5'b0, ncs, copi, sclk};
    assign uio_in = 8'h00;

    spi_pwm_peripheral #(.PWM_DIV(PWM_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Clock edges since reset was last released
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (rst_n) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    logic [7:0] mreg [5];

    task automatic model_reset();
        for (int i = 0; i < 5; i++) mreg[i] = 8'h00;
    endtask

    task automatic model_apply(input logic [31:0] bits, input int n);
        logic [15:0] f;
        f = bits[15:0];
        if (n == 16 && f[15] && f[14:8] <= 7'd4) mreg[int'(f[14:8])] = f[7:0];
    endtask

    // Expected {uio_out, uo_out}: outputs reflect the phase one clock earlier
    function automatic logic [15:0] model_out();
        logic [15:0] eo, ep;
        logic p;
        int unsigned ph;
        eo = {mreg[1], mreg[0]};
        ep = {mreg[3], mreg[2]};
        if (cyc == 0) return 16'h0000;
        ph = ((cyc - 1) / PWM_DIV) % 256;
        p  = (mreg[4] == 8'hFF) || (ph < int'(mreg[4]));
        return eo & (~ep | {16{p}});
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s got=%0d exp=[%0d..%0d]", name, got, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_send(input logic [31:0] bits, input int n);
        ncs = 1'b0;
        wait_clk(5);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        wait_clk(5);
        ncs = 1'b1;
    endtask

    // Sends a frame and waits the maximum commit-to-output latency
    task automatic send_frame(input logic [31:0] bits, input int n);
        spi_send(bits, n);
        model_apply(bits, n);
        wait_clk(5);
    endtask

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int r1, r2, f1, hi_cnt, lo_cnt;
        logic prev_b;

        tbl[0]  = '{32'h0000_80F0, 16, 16'h00F0, "wr0_F0"};
        tbl[1]  = '{32'h0000_81CC, 16, 16'hCCF0, "wr1_CC"};
        tbl[2]  = '{32'h0000_0055, 16, 16'hCCF0, "read_rejected"};
        tbl[3]  = '{32'h0000_85AA, 16, 16'hCCF0, "addr5_rejected"};
        tbl[4]  = '{32'h0000_40FF, 15, 16'hCCF0, "short15_rejected"};
        tbl[5]  = '{32'h0001_8011, 17, 16'hCCF0, "long17_rejected"};
        tbl[6]  = '{32'h0000_803C, 16, 16'hCC3C, "wr0_3C"};
        tbl[7]  = '{32'h0000_8100, 16, 16'h003C, "wr1_00"};
        tbl[8]  = '{32'h0000_820F, 16, 16'h0030, "pwm_duty0"};
        tbl[9]  = '{32'h0000_84FF, 16, 16'h003C, "duty_ff"};
        tbl[10] = '{32'h0000_8400, 16, 16'h0030, "duty_00"};
        tbl[11] = '{32'h0000_8200, 16, 16'h003C, "pwm_off"};

        // Reset
        model_reset();
        rst_n = 1'b1;
        wait_clk(5);
        check("rst_uo", {8'h00, uo_out}, 16'h0000);
        check("rst_uio", {8'h00, uio_out}, 16'h0000);
        check("rst_oe", {8'h00, uio_oe}, 16'h00FF);
        rst_n = 1'b0;
        wait_clk(3);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            send_frame(tbl[i].bits, tbl[i].n);
            check(tbl[i].name, {uio_out, uo_out}, tbl[i].exp);
        end

        // PWM at 50 %
        send_frame(32'h0000_8001, 16);
        send_frame(32'h0000_8201, 16);
        send_frame(32'h0000_8480, 16);
        r1 = -1; r2 = -1; f1 = -1;
        prev_b = uo_out[0];
        for (int c = 0; c < 4 * PERIOD && r2 < 0; c++) begin
            wait_clk(1);
            if (uo_out[0] && !prev_b) begin
                if (r1 < 0) r1 = c;
                else        r2 = c;
            end
            if (!uo_out[0] && prev_b && r1 >= 0 && f1 < 0) f1 = c;
            prev_b = uo_out[0];
        end
        if (r2 < 0 || f1 < 0) begin
            check_range("pwm_edges_found", 0, 1, 1);
        end else begin
            check_range("pwm_period", r2 - r1, PERIOD - 1, PERIOD + 1);
            check_range("pwm_high", f1 - r1, PERIOD / 2 - 13, PERIOD / 2 + 13);
        end

        // Duty extremes
        send_frame(32'h0000_8400, 16);
        hi_cnt = 0;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            wait_clk(1);
            if (uo_out[0]) hi_cnt++;
        end
        check_range("duty00_high_samples", hi_cnt, 0, 0);
        send_frame(32'h0000_84FF, 16);
        lo_cnt = 0;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            wait_clk(1);
            if (!uo_out[0]) lo_cnt++;
        end
        check_range("duty_ff_low_samples", lo_cnt, 0, 0);

        // Reset after 8 bits of a frame
        ncs = 1'b0;
        wait_clk(5);
        for (int i = 15; i >= 8; i--) begin
            copi = 1'b1;
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        rst_n = 1'b1;
        wait_clk(2);
        check("midrst_out", {uio_out, uo_out}, 16'h0000);
        ncs = 1'b1;
        wait_clk(3);
        rst_n = 1'b0;
        model_reset();
        wait_clk(3);
        send_frame(32'h0000_800F, 16);
        check("midrst_wr0_0F", {uio_out, uo_out}, 16'h000F);

        // Random frames against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [15:0] f;
            logic [31:0] b;
            int n, sel;
            f[15]   = ($urandom_range(0, 3) != 0);
            f[14:8] = 7'($urandom_range(0, 7));
            f[7:0]  = 8'($urandom);
            sel = $urandom_range(0, 5);
            n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            b = {15'h0, 1'($urandom), f};
            if (n == 15) b = {17'h0, f[15:1]};
            send_frame(b, n);
            check($sformatf("rnd%0d_post", k), {uio_out, uo_out}, model_out());
            wait_clk($urandom_range(0, 200));
            check($sformatf("rnd%0d_late", k), {uio_out, uo_out}, model_out());
        end
        check("oe_end", {8'h00, uio_oe}, 16'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
